// File: rtl/fifo_rd_burst_arb_pkg.sv
// Shared definitions for the FIFO read-side burst arbiter: FSM state encodings
// and the requester-index width helper.
package fifo_rd_burst_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BURST = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;

  // Index width for n requesters, never narrower than one bit
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_burst_arb_if.sv
// Bundle of request, FIFO read-port and output-beat signals around the arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface fifo_rd_burst_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
);
  import fifo_rd_burst_arb_pkg::*;

  localparam int IDW = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*LEN_WIDTH-1:0] req_len;
  logic [NUM_REQ-1:0]           gnt;
  logic                         empty;
  logic [DATA_WIDTH-1:0]        r_data;
  logic                         r_en;
  logic                         out_valid;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [IDW-1:0]               out_id;
  logic                         out_last;
  logic                         out_ready;

  modport slave (
    input  req, req_len, empty, r_data, out_ready,
    output gnt, r_en, out_valid, out_data, out_id, out_last
  );

  modport master (
    output req, req_len, empty, r_data, out_ready,
    input  gnt, r_en, out_valid, out_data, out_id, out_last
  );

endinterface

// File: rtl/fifo_rd_burst_arb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping, returned as a one-hot vector and an index.
module fifo_rd_burst_arb_rr_arbiter
  import fifo_rd_burst_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IDW-1:0]     idx,
  output logic               found
);

  logic [IDW-1:0] cand_s;

  // Scan outward from the pointer; the first hit locks the result
  always_comb begin
    win    = '0;
    idx    = '0;
    found  = 1'b0;
    cand_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand_s]) begin
        found       = 1'b1;
        idx         = cand_s;
        win         = '0;
        win[cand_s] = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_burst_arb.sv
// Read-side scheduler sharing one FIFO read port among NUM_REQ consumers with
// round-robin, burst-granular grants and a single-entry output slot.
module fifo_rd_burst_arb
  import fifo_rd_burst_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                r_clk,
  input  logic                r_rst_n,
  fifo_rd_burst_arb_if.slave  bus
);

  localparam int IDW = id_width(NUM_REQ);

  state_t                  state_r;
  logic [NUM_REQ-1:0]      gnt_r;
  logic [IDW-1:0]          id_r;
  logic [IDW-1:0]          rr_ptr_r;
  logic [LEN_WIDTH-1:0]    cnt_r;
  logic                    out_valid_r;
  logic                    out_last_r;
  logic [DATA_WIDTH-1:0]   out_data_r;

  logic [NUM_REQ-1:0]      win_s;
  logic [IDW-1:0]          win_idx_s;
  logic                    win_found_s;
  logic [LEN_WIDTH-1:0]    win_len_s;
  logic [IDW-1:0]          next_ptr_s;
  logic                    pop_s;
  logic                    accept_s;

  fifo_rd_burst_arb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_arbiter (
    .req   (bus.req),
    .ptr   (rr_ptr_r),
    .win   (win_s),
    .idx   (win_idx_s),
    .found (win_found_s)
  );

  // Burst length of the current winner, sampled only at grant time
  always_comb begin
    win_len_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx_s == IDW'(k)) begin
        win_len_s = bus.req_len[k*LEN_WIDTH +: LEN_WIDTH];
      end else begin
        win_len_s = win_len_s;
      end
    end
  end

  // Pop only while bursting, never from an empty FIFO, never into a full slot
  always_comb begin
    pop_s    = (state_r == ST_BURST) && !bus.empty && (!out_valid_r || bus.out_ready);
    accept_s = out_valid_r && bus.out_ready;
    if (id_r == IDW'(NUM_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = id_r + IDW'(1);
    end
  end

  // Grant FSM, beat counter and round-robin pointer
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      state_r  <= ST_IDLE;
      gnt_r    <= '0;
      id_r     <= '0;
      cnt_r    <= '0;
      rr_ptr_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            gnt_r   <= win_s;
            id_r    <= win_idx_s;
            cnt_r   <= win_len_s;
            state_r <= ST_BURST;
          end
        end
        ST_BURST: begin
          // Counter parks at zero on the last pop instead of wrapping
          if (pop_s) begin
            if (cnt_r == '0) begin
              state_r <= ST_FLUSH;
            end else begin
              cnt_r <= cnt_r - LEN_WIDTH'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (accept_s) begin
            state_r  <= ST_IDLE;
            gnt_r    <= '0;
            rr_ptr_r <= next_ptr_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          gnt_r   <= '0;
        end
      endcase
    end
  end

  // Single-entry output slot: refill on pop, drain on accept
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
    end else if (pop_s) begin
      out_valid_r <= 1'b1;
      out_last_r  <= (cnt_r == '0);
      out_data_r  <= bus.r_data;
    end else if (accept_s) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.r_en      = pop_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_id    = id_r;
  assign bus.out_last  = out_last_r;

endmodule
